// File: rtl/l2_mem_block_xfer.sv
// l2_mem_block_xfer: L2-side initiator for the main-memory word port.
// Breaks one L2 block request (line fill or writeback) into BLOCK_WORDS
// single-word memory transactions. Fills come back critical-word-first and
// stream to L2 one word at a time. Writebacks read the L2 array by word index.
module l2_mem_block_xfer #(
   parameter  int n           = 32,
   parameter  int BLOCK_WORDS = 16,
   parameter  int ADDR_W      = 15,
   localparam int OFF_W       = $clog2(BLOCK_WORDS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    blk_req_valid,
   input  logic                    blk_req_write,
   input  logic [ADDR_W-OFF_W-1:0] blk_req_addr,
   input  logic [OFF_W-1:0]        blk_req_offset,
   output logic                    blk_ready,
   output logic                    blk_done,
   output logic [OFF_W-1:0]        wb_word_idx,
   input  logic [n-1:0]            wb_word_data,
   output logic                    fill_valid,
   output logic [OFF_W-1:0]        fill_word_idx,
   output logic [n-1:0]            fill_data,
   output logic                    L2_read_request,
   output logic                    L2_write_request,
   output logic [ADDR_W-1:0]       L2_word_address,
   output logic [n-1:0]            L2_wdata,
   input  logic [n-1:0]            L2_rdata,
   input  logic                    MM_busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      ACTIVE = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                  state;
   logic                    write_q;
   logic [ADDR_W-OFF_W-1:0] blk_addr_q;
   logic [OFF_W-1:0]        index;
   logic [OFF_W-1:0]        count;
   logic                    req_phase;

   // The request line is held from ISSUE through ACTIVE so memory sees it at
   // its access edge; it drops in RESP so the same word is never re-accessed.
   assign req_phase        = (state == ISSUE) || (state == ACTIVE);
   assign L2_read_request  = req_phase && !write_q;
   assign L2_write_request = req_phase && write_q;
   assign L2_word_address  = {blk_addr_q, index};
   assign L2_wdata         = wb_word_data;
   assign wb_word_idx      = index;
   assign blk_ready        = (state == IDLE);

   // Block sequencer: accepts a request, walks every word of the block with
   // wrap-around indexing, and produces the fill/done pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         write_q       <= 1'b0;
         blk_addr_q    <= {(ADDR_W-OFF_W){1'b0}};
         index         <= {OFF_W{1'b0}};
         count         <= {OFF_W{1'b0}};
         fill_data     <= {n{1'b0}};
         fill_word_idx <= {OFF_W{1'b0}};
         fill_valid    <= 1'b0;
         blk_done      <= 1'b0;
      end else begin
         fill_valid <= 1'b0;
         blk_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (blk_req_valid) begin
                  write_q    <= blk_req_write;
                  blk_addr_q <= blk_req_addr;
                  // Writebacks always start at word 0; fills start at the critical word.
                  index      <= blk_req_write ? {OFF_W{1'b0}} : blk_req_offset;
                  count      <= {OFF_W{1'b0}};
                  state      <= ISSUE;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               if (!MM_busy) begin
                  state <= ACTIVE;
               end else begin
                  state <= ISSUE;
               end
            end
            ACTIVE: begin
               if (MM_busy) begin
                  state <= RESP;
               end else begin
                  state <= ACTIVE;
               end
            end
            RESP: begin
               if (!write_q) begin
                  fill_data     <= L2_rdata;
                  fill_word_idx <= index;
                  fill_valid    <= 1'b1;
               end else begin
                  fill_valid <= 1'b0;
               end
               // Index wraps naturally at the power-of-two block size.
               index <= index + OFF_W'(1);
               count <= count + OFF_W'(1);
               if (count == OFF_W'(BLOCK_WORDS - 1)) begin
                  blk_done <= 1'b1;
                  state    <= IDLE;
               end else begin
                  state <= ISSUE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_mem_block_xfer.sv
// Self-checking bench for l2_mem_block_xfer: a word-level memory model,
// a block-level reference memory, and a scoreboard of expected fill/done events.
module tb_l2_mem_block_xfer;
   localparam int N   = 32;
   localparam int BW  = 16;
   localparam int AW  = 15;
   localparam int OW  = 4;
   localparam int BAW = AW - OW;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           blk_req_valid = 1'b0;
   logic           blk_req_write = 1'b0;
   logic [BAW-1:0] blk_req_addr = '0;
   logic [OW-1:0]  blk_req_offset = '0;
   logic           blk_ready, blk_done, fill_valid;
   logic [OW-1:0]  wb_word_idx, fill_word_idx;
   logic [N-1:0]   wb_word_data, fill_data, L2_wdata;
   logic [N-1:0]   L2_rdata = '0;
   logic           L2_read_request, L2_write_request;
   logic [AW-1:0]  L2_word_address;
   logic           MM_busy = 1'b0;

   always #5 clk = ~clk;

   l2_mem_block_xfer dut (
      .clk(clk), .reset(reset),
      .blk_req_valid(blk_req_valid), .blk_req_write(blk_req_write),
      .blk_req_addr(blk_req_addr), .blk_req_offset(blk_req_offset),
      .blk_ready(blk_ready), .blk_done(blk_done),
      .wb_word_idx(wb_word_idx), .wb_word_data(wb_word_data),
      .fill_valid(fill_valid), .fill_word_idx(fill_word_idx), .fill_data(fill_data),
      .L2_read_request(L2_read_request), .L2_write_request(L2_write_request),
      .L2_word_address(L2_word_address), .L2_wdata(L2_wdata),
      .L2_rdata(L2_rdata), .MM_busy(MM_busy)
   );

   // L2 data array content for writebacks
   assign wb_word_data = 32'hC0DE0000 | {28'd0, wb_word_idx};

   function automatic logic [N-1:0] init_word(input int a);
      if (a >= 32'h50 && a < 32'h60) return 32'h0000A000 + (a - 32'h50);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   logic [N-1:0] mem     [0:(1<<AW)-1];
   logic [N-1:0] ref_mem [0:(1<<AW)-1];
   int cyc = 0, rd_tot = 0, wr_tot = 0, both_viol = 0;

   // Memory model: idle -> (request seen) access edge, busy for one cycle -> idle
   initial begin
      for (int a = 0; a < (1 << AW); a++) mem[a] = init_word(a);
      forever begin
         @(posedge clk);
         cyc <= cyc + 1;
         if (L2_read_request && L2_write_request) both_viol <= both_viol + 1;
         if (!reset) MM_busy <= 1'b0;
         else if (MM_busy) MM_busy <= 1'b0;
         else if (L2_write_request) begin
            MM_busy <= 1'b1;
            mem[L2_word_address] <= L2_wdata;
            wr_tot <= wr_tot + 1;
         end else if (L2_read_request) begin
            MM_busy <= 1'b1;
            L2_rdata <= mem[L2_word_address];
            rd_tot <= rd_tot + 1;
         end
      end
   end

   typedef struct {
      bit          fill;
      bit          done;
      bit          wr;
      logic [3:0]  idx;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents fill_valid or blk_done
   exp_t mon_e;
   int base_rd = 0, base_wr = 0;
   always @(negedge clk) begin
      if (!reset) begin
         base_rd = rd_tot;
         base_wr = wr_tot;
      end else if (fill_valid || blk_done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: fill_valid=%0b blk_done=%0b with nothing expected (cycle %0d)",
                     fill_valid, blk_done, cyc);
         end else begin
            mon_e = q.pop_front();
            chk("event_cycle", cyc, mon_e.cyc);
            chk("fill_valid", fill_valid, mon_e.fill);
            chk("blk_done", blk_done, mon_e.done);
            if (mon_e.fill) begin
               chk("fill_word_idx", fill_word_idx, mon_e.idx);
               chk("fill_data", fill_data, mon_e.data);
            end
            if (mon_e.done) begin
               chk("blk_ready_at_done", blk_ready, 1'b1);
               chk("read_accesses", rd_tot - base_rd, mon_e.wr ? 0 : BW);
               chk("write_accesses", wr_tot - base_wr, mon_e.wr ? BW : 0);
               base_rd = rd_tot;
               base_wr = wr_tot;
            end
         end
      end
   end

   // Present a request (called at a negedge) and push its expected events.
   task automatic issue(input bit wr, input logic [BAW-1:0] blk, input logic [OW-1:0] off,
                        input bit hold, output int t);
      int waited = 0;
      logic [3:0] idx;
      exp_t e;
      blk_req_valid  = 1'b1;
      blk_req_write  = wr;
      blk_req_addr   = blk;
      blk_req_offset = off;
      t = -1;
      while (!blk_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!blk_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: blk_ready stayed 0 for %0d cycles, expected 1", waited);
         blk_req_valid = 1'b0;
         return;
      end
      t = cyc + 1;
      if (wr) begin
         for (int i = 0; i < BW; i++) ref_mem[{blk, 4'(i)}] = 32'hC0DE0000 | i;
         e = '{fill: 1'b0, done: 1'b1, wr: 1'b1, idx: 4'd0, data: 32'd0, cyc: t + 3 * BW};
         q.push_back(e);
      end else begin
         for (int k = 0; k < BW; k++) begin
            idx = off + 4'(k);
            e = '{fill: 1'b1, done: (k == BW - 1), wr: 1'b0, idx: idx,
                  data: ref_mem[{blk, idx}], cyc: t + 3 * (k + 1)};
            q.push_back(e);
         end
      end
      @(negedge clk);
      chk("blk_ready_busy", blk_ready, 1'b0);
      if (!hold) blk_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      while (q.size() != 0 && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: %0d events still pending, expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   int t0, t1, bad;

   initial begin
      for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_word(a);
      repeat (3) @(negedge clk);
      // reset state
      chk("rst_blk_ready", blk_ready, 1'b1);
      chk("rst_blk_done", blk_done, 1'b0);
      chk("rst_fill_valid", fill_valid, 1'b0);
      chk("rst_read_req", L2_read_request, 1'b0);
      chk("rst_write_req", L2_write_request, 1'b0);
      chk("rst_word_addr", L2_word_address, 15'd0);
      chk("rst_fill_data", fill_data, 32'd0);
      chk("rst_fill_idx", fill_word_idx, 4'd0);
      chk("rst_wb_idx", wb_word_idx, 4'd0);
      reset = 1'b1;
      @(negedge clk);

      // linear fill of block 0x005
      issue(1'b0, 11'h005, 4'd0, 1'b0, t0);
      wait_idle();
      // wrapped fill of the top block
      issue(1'b0, 11'h7FF, 4'd14, 1'b0, t0);
      wait_idle();
      // writeback of block 0x123; offset is ignored
      issue(1'b1, 11'h123, 4'd9, 1'b0, t0);
      wait_idle();
      for (int i = 0; i < BW; i++) chk("wb_mem", mem[{11'h123, 4'(i)}], 32'hC0DE0000 | i);
      // read back the written block
      issue(1'b0, 11'h123, 4'd3, 1'b0, t0);
      wait_idle();

      // request held through a fill: accepted on the cycle blk_done is high
      issue(1'b0, 11'h2A5, 4'd7, 1'b1, t0);
      issue(1'b1, 11'h0F0, 4'd0, 1'b0, t1);
      chk("b2b_accept_edge", t1, t0 + 3 * BW + 1);
      wait_idle();

      // reset during word 5 of a fill abandons the block
      issue(1'b0, 11'h3C3, 4'd11, 1'b0, t0);
      for (int w = 0; w < 100 && q.size() > BW - 5; w++) @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      @(negedge clk);
      chk("midrst_read_req", L2_read_request, 1'b0);
      chk("midrst_write_req", L2_write_request, 1'b0);
      chk("midrst_blk_ready", blk_ready, 1'b1);
      chk("midrst_blk_done", blk_done, 1'b0);
      chk("midrst_fill_valid", fill_valid, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      issue(1'b0, 11'h3C3, 4'd11, 1'b0, t0);
      wait_idle();

      // randomized blocks, some back-to-back with the request held high
      for (int r = 0; r < 12; r++) begin
         bit hold;
         hold = 1'($urandom_range(0, 1));
         issue(1'($urandom_range(0, 1)), 11'($urandom), 4'($urandom), hold, t0);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      blk_req_valid = 1'b0;
      wait_idle();

      chk("both_requests_high", both_viol, 0);
      bad = 0;
      for (int a = 0; a < (1 << AW); a++) if (mem[a] !== ref_mem[a]) bad++;
      chk("mem_final_mismatches", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
